// File: rtl/rv32_mem_pkg.sv
// Shared encodings for the RV32I memory-access / writeback stage:
// writeback source select, load/store fun3 codes and FSM state encoding.
package rv32_mem_pkg;

  typedef enum logic [1:0] {
    M2R_ALU  = 2'b00,
    M2R_LOAD = 2'b01,
    M2R_PC4  = 2'b10,
    M2R_ALU2 = 2'b11
  } mem_to_reg_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_WAIT = 1'b1;

endpackage

// File: rtl/load_store_align.sv
// Combinational lane logic: store byte mask / lane-replicated data, load byte/half
// extraction with sign or zero extension, and misalignment detection.
module load_store_align
  import rv32_mem_pkg::*;
(
  input  logic        is_load,
  input  logic [2:0]  fun3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] store_data,
  input  logic [31:0] rdata,
  output logic [3:0]  st_mask,
  output logic [31:0] st_wdata,
  output logic [31:0] ld_data,
  output logic        misaligned
);

  logic [31:0] byte_sh;
  logic [31:0] half_sh;

  assign byte_sh = rdata >> {addr_lo, 3'b000};
  assign half_sh = rdata >> {addr_lo[1], 4'b0000};

  // NOTE: every output gets a default first so no path through the case infers a latch.
  always_comb begin
    st_mask  = 4'b1111;
    st_wdata = store_data;
    ld_data  = rdata;
    unique case (fun3)
      F3_B: begin
        st_mask  = 4'b0001 << addr_lo;
        st_wdata = {4{store_data[7:0]}};
      end
      F3_H: begin
        st_mask  = 4'b0011 << {addr_lo[1], 1'b0};
        st_wdata = {2{store_data[15:0]}};
      end
      default: ;
    endcase

    case (fun3)
      F3_B:    ld_data = {{24{byte_sh[7]}}, byte_sh[7:0]};
      F3_BU:   ld_data = {24'd0, byte_sh[7:0]};
      F3_H:    ld_data = {{16{half_sh[15]}}, half_sh[15:0]};
      F3_HU:   ld_data = {16'd0, half_sh[15:0]};
      default: ld_data = rdata;
    endcase

    // Stores only know SB/SH; their 100/101 codes fall back to word rules.
    case (fun3)
      F3_B:    misaligned = 1'b0;
      F3_BU:   misaligned = is_load ? 1'b0 : (addr_lo != 2'b00);
      F3_H:    misaligned = addr_lo[0];
      F3_HU:   misaligned = is_load ? addr_lo[0] : (addr_lo != 2'b00);
      default: misaligned = (addr_lo != 2'b00);
    endcase
  end

endmodule

// File: rtl/memory_writeback_stage.sv
// RV32I memory-access + writeback stage: issues one data-memory request per memory op,
// waits for DM_valid, then drives the register-file write port back to decode.
module memory_writeback_stage
  import rv32_mem_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int INSTRUCTION = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DATA_WIDTH-1:0]  alu_result,
  input  logic [DATA_WIDTH-1:0]  store_data,
  input  logic [DATA_WIDTH-1:0]  pc,
  input  logic [INSTRUCTION-1:0] instruction,
  input  logic                   reg_write,
  input  logic                   load,
  input  logic                   store,
  input  logic                   mem_en,
  input  logic [1:0]             mem_to_reg,
  output logic                   dm_req,
  output logic                   dm_we,
  output logic [DATA_WIDTH-1:0]  dm_addr,
  output logic [DATA_WIDTH-1:0]  dm_wdata,
  output logic [3:0]             dm_mask,
  input  logic [DATA_WIDTH-1:0]  dm_rdata,
  input  logic                   DM_valid,
  output logic                   decode_reg_write_pp,
  output logic [DATA_WIDTH-1:0]  rwd_data_out,
  output logic [INSTRUCTION-1:0] instruction_rd,
  output logic                   misalign_fault
);

  logic [0:0]             state_q, state_d;
  logic                   dm_req_q, dm_req_d, dm_we_q, dm_we_d;
  logic [DATA_WIDTH-1:0]  dm_addr_q, dm_addr_d, dm_wdata_q, dm_wdata_d;
  logic [3:0]             dm_mask_q, dm_mask_d;
  logic                   pp_q, pp_d, fault_q, fault_d;
  logic [DATA_WIDTH-1:0]  rwd_q, rwd_d, hold_alt_q, hold_alt_d;
  logic [INSTRUCTION-1:0] ird_q, ird_d, hold_instr_q, hold_instr_d;
  logic [1:0]             hold_lo_q, hold_lo_d, hold_m2r_q, hold_m2r_d;
  logic                   hold_wr_q, hold_wr_d;

  logic                   in_wait, accept, is_mem, rd_nz;
  logic [DATA_WIDTH-1:0]  alu_path;
  logic [3:0]             st_mask;
  logic [31:0]            st_wdata, ld_data;
  logic                   misaligned;

  assign in_wait  = (state_q == ST_WAIT);
  assign in_ready = (state_q == ST_IDLE);
  assign accept   = in_valid & in_ready;
  assign is_mem   = mem_en & (load | store);
  assign rd_nz    = (instruction[11:7] != 5'd0);
  assign alu_path = (mem_to_reg_e'(mem_to_reg) == M2R_PC4) ? pc + 32'd4 : alu_result;

  // In WAIT the lane logic extracts load data for the held op; in IDLE it checks the incoming op.
  load_store_align u_align (
    .is_load    (in_wait ? 1'b1 : load),
    .fun3       (in_wait ? hold_instr_q[14:12] : instruction[14:12]),
    .addr_lo    (in_wait ? hold_lo_q : alu_result[1:0]),
    .store_data (store_data),
    .rdata      (dm_rdata),
    .st_mask    (st_mask),
    .st_wdata   (st_wdata),
    .ld_data    (ld_data),
    .misaligned (misaligned)
  );

  always_comb begin
    state_d      = state_q;
    dm_req_d     = dm_req_q;
    dm_we_d      = dm_we_q;
    dm_addr_d    = dm_addr_q;
    dm_wdata_d   = dm_wdata_q;
    dm_mask_d    = dm_mask_q;
    rwd_d        = rwd_q;
    ird_d        = ird_q;
    hold_alt_d   = hold_alt_q;
    hold_instr_d = hold_instr_q;
    hold_lo_d    = hold_lo_q;
    hold_m2r_d   = hold_m2r_q;
    hold_wr_d    = hold_wr_q;
    pp_d         = 1'b0;
    fault_d      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept && is_mem && misaligned) begin
          fault_d = 1'b1;
        end else if (accept && is_mem) begin
          state_d      = ST_WAIT;
          dm_req_d     = 1'b1;
          dm_we_d      = ~load;
          dm_addr_d    = {alu_result[31:2], 2'b00};
          dm_wdata_d   = load ? '0 : st_wdata;
          dm_mask_d    = load ? 4'b0000 : st_mask;
          hold_instr_d = instruction;
          hold_lo_d    = alu_result[1:0];
          hold_m2r_d   = mem_to_reg;
          hold_alt_d   = alu_path;
          hold_wr_d    = load & reg_write & rd_nz;
        end else if (accept) begin
          rwd_d = alu_path;
          ird_d = instruction;
          pp_d  = reg_write & rd_nz;
        end
      end
      default: begin
        if (DM_valid) begin
          state_d  = ST_IDLE;
          dm_req_d = 1'b0;
          pp_d     = hold_wr_q;
          if (!dm_we_q) begin
            rwd_d = (mem_to_reg_e'(hold_m2r_q) == M2R_LOAD) ? ld_data : hold_alt_q;
            ird_d = hold_instr_q;
          end
        end
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so all flops update together.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      dm_req_q     <= 1'b0;
      dm_we_q      <= 1'b0;
      dm_addr_q    <= '0;
      dm_wdata_q   <= '0;
      dm_mask_q    <= 4'b0000;
      pp_q         <= 1'b0;
      fault_q      <= 1'b0;
      rwd_q        <= '0;
      ird_q        <= '0;
      hold_alt_q   <= '0;
      hold_instr_q <= '0;
      hold_lo_q    <= 2'b00;
      hold_m2r_q   <= 2'b00;
      hold_wr_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      dm_req_q     <= dm_req_d;
      dm_we_q      <= dm_we_d;
      dm_addr_q    <= dm_addr_d;
      dm_wdata_q   <= dm_wdata_d;
      dm_mask_q    <= dm_mask_d;
      pp_q         <= pp_d;
      fault_q      <= fault_d;
      rwd_q        <= rwd_d;
      ird_q        <= ird_d;
      hold_alt_q   <= hold_alt_d;
      hold_instr_q <= hold_instr_d;
      hold_lo_q    <= hold_lo_d;
      hold_m2r_q   <= hold_m2r_d;
      hold_wr_q    <= hold_wr_d;
    end
  end

  assign dm_req              = dm_req_q;
  assign dm_we               = dm_we_q;
  assign dm_addr             = dm_addr_q;
  assign dm_wdata            = dm_wdata_q;
  assign dm_mask             = dm_mask_q;
  assign decode_reg_write_pp = pp_q;
  assign rwd_data_out        = rwd_q;
  assign instruction_rd      = ird_q;
  assign misalign_fault      = fault_q;

endmodule

// File: tb/tb_memory_writeback_stage.sv
// Self-checking bench for memory_writeback_stage: directed cases plus randomized ops
// checked against a byte-lane reference model built from access sizes and arithmetic.
module tb_memory_writeback_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [31:0] alu_result, store_data, pc, instruction;
  logic        reg_write, load, store, mem_en;
  logic [1:0]  mem_to_reg;
  logic        dm_req, dm_we;
  logic [31:0] dm_addr, dm_wdata, dm_rdata;
  logic [3:0]  dm_mask;
  logic        DM_valid;
  logic        decode_reg_write_pp, misalign_fault;
  logic [31:0] rwd_data_out, instruction_rd;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] exp_rwd, exp_ird;

  always #5 clk = ~clk;

  memory_writeback_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .alu_result(alu_result), .store_data(store_data), .pc(pc), .instruction(instruction),
    .reg_write(reg_write), .load(load), .store(store), .mem_en(mem_en), .mem_to_reg(mem_to_reg),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_mask(dm_mask),
    .dm_rdata(dm_rdata), .DM_valid(DM_valid), .decode_reg_write_pp(decode_reg_write_pp),
    .rwd_data_out(rwd_data_out), .instruction_rd(instruction_rd), .misalign_fault(misalign_fault)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Access size in bytes; stores only have byte and half forms, everything else is a word.
  function automatic int m_size(input bit ld, input logic [2:0] f3);
    if (f3 == 3'b000 || (ld && f3 == 3'b100)) return 1;
    if (f3 == 3'b001 || (ld && f3 == 3'b101)) return 2;
    return 4;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [1:0] a,
                                         input logic [31:0] word);
    int sz;
    logic [31:0] lane, v;
    sz = m_size(1'b1, f3);
    if (sz == 4) return word;
    lane = (32'd1 << (8 * sz)) - 32'd1;
    v = (word >> (8 * int'(a))) & lane;
    if ((f3 == 3'b000 || f3 == 3'b001) && v[8*sz-1]) v = v | ~lane;
    return v;
  endfunction

  function automatic logic [31:0] m_wdata(input int sz, input logic [31:0] d);
    logic [31:0] w;
    for (int i = 0; i < 4; i++) w[8*i +: 8] = d[8*(i % sz) +: 8];
    return w;
  endfunction

  // Drives one op starting just after a rising edge, models and checks its whole lifetime.
  task automatic run_op(input logic v_en, input logic v_ld, input logic v_st,
                        input logic [31:0] instr, input logic [31:0] addr, input logic [31:0] sdata,
                        input logic [31:0] pcv, input logic [1:0] m2r, input logic rw,
                        input logic [31:0] rdata, input int lat);
    bit mem, mis, wr;
    int sz;
    mem = v_en && (v_ld || v_st);
    sz  = m_size(v_ld, instr[14:12]);
    mis = mem && ((int'(addr[1:0]) % sz) != 0);
    wr  = rw && (instr[11:7] != 5'd0);
    check("in_ready_idle", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1; mem_en = v_en; load = v_ld; store = v_st; instruction = instr;
    alu_result = addr; store_data = sdata; pc = pcv; mem_to_reg = m2r; reg_write = rw;
    @(posedge clk); #1;
    in_valid = 1'b0; alu_result = $urandom; store_data = $urandom; instruction = $urandom;
    if (!mem) begin
      exp_rwd = (m2r == 2'b10) ? pcv + 32'd4 : addr;
      exp_ird = instr;
      check("alu_pp", {31'd0, decode_reg_write_pp}, {31'd0, wr});
      check("alu_no_req", {31'd0, dm_req}, 32'd0);
    end else if (mis) begin
      check("mis_fault", {31'd0, misalign_fault}, 32'd1);
      check("mis_no_req", {31'd0, dm_req}, 32'd0);
      check("mis_no_pp", {31'd0, decode_reg_write_pp}, 32'd0);
      check("mis_ready", {31'd0, in_ready}, 32'd1);
    end else begin
      check("mem_req", {31'd0, dm_req}, 32'd1);
      check("mem_we", {31'd0, dm_we}, {31'd0, !v_ld});
      check("mem_addr", dm_addr, {addr[31:2], 2'b00});
      if (!v_ld) begin
        check("st_mask", {28'd0, dm_mask}, ((32'd1 << sz) - 32'd1) << addr[1:0]);
        check("st_wdata", dm_wdata, m_wdata(sz, sdata));
      end
      for (int c = 0; c < lat; c++) begin
        check("wait_ready", {31'd0, in_ready}, 32'd0);
        @(posedge clk); #1;
        check("wait_req", {31'd0, dm_req}, 32'd1);
        check("wait_addr", dm_addr, {addr[31:2], 2'b00});
      end
      dm_rdata = rdata; DM_valid = 1'b1;
      @(posedge clk); #1;
      DM_valid = 1'b0; dm_rdata = $urandom;
      check("done_req", {31'd0, dm_req}, 32'd0);
      check("done_ready", {31'd0, in_ready}, 32'd1);
      check("done_pp", {31'd0, decode_reg_write_pp}, {31'd0, v_ld && wr});
      if (v_ld) begin
        exp_rwd = m_load(instr[14:12], addr[1:0], rdata);
        exp_ird = instr;
      end
    end
    check("rwd", rwd_data_out, exp_rwd);
    check("ird", instruction_rd, exp_ird);
    @(posedge clk); #1;
    check("pp_pulse_end", {31'd0, decode_reg_write_pp}, 32'd0);
    check("fault_pulse_end", {31'd0, misalign_fault}, 32'd0);
  endtask

  function automatic logic [31:0] mk_instr(input logic [2:0] f3, input logic [4:0] rd);
    logic [31:0] r;
    r = $urandom;
    r[14:12] = f3;
    r[11:7]  = rd;
    return r;
  endfunction

  initial begin
    logic [31:0] a;
    int kind;
    rst = 1'b0; in_valid = 1'b0; alu_result = '0; store_data = '0; pc = '0; instruction = '0;
    reg_write = 1'b0; load = 1'b0; store = 1'b0; mem_en = 1'b0; mem_to_reg = 2'b00;
    dm_rdata = '0; DM_valid = 1'b0;
    exp_rwd = '0; exp_ird = '0;
    #12;
    check("rst_req", {31'd0, dm_req}, 32'd0);
    check("rst_pp", {31'd0, decode_reg_write_pp}, 32'd0);
    check("rst_fault", {31'd0, misalign_fault}, 32'd0);
    check("rst_mask", {28'd0, dm_mask}, 32'd0);
    check("rst_addr", dm_addr, 32'd0);
    check("rst_rwd", rwd_data_out, 32'd0);
    check("rst_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;

    // ADD x5
    run_op(0, 0, 0, {17'd0, 3'b000, 5'd5, 7'b0110011}, 32'h1234, 0, 32'h10, 2'b00, 1, 0, 0);
    check("add_rwd_lit", rwd_data_out, 32'h1234);
    // LB from 0x103, response after 3 wait cycles
    run_op(1, 1, 0, mk_instr(3'b000, 5'd7), 32'h103, 0, 32'h20, 2'b01, 1, 32'h80FF_FF00, 3);
    check("lb_rwd_lit", rwd_data_out, 32'hFFFF_FF80);
    // SH to 0x202
    run_op(1, 0, 1, mk_instr(3'b001, 5'd9), 32'h202, 32'h0000_ABCD, 32'h24, 2'b00, 1, 0, 1);
    // LW misaligned
    run_op(1, 1, 0, mk_instr(3'b010, 5'd3), 32'h101, 0, 32'h28, 2'b01, 1, 0, 0);
    // JAL-style link, rd=x0 write suppression, pc+4 wrap
    run_op(0, 0, 0, mk_instr(3'b000, 5'd1), 32'h999, 0, 32'h40, 2'b10, 1, 0, 0);
    check("jal_rwd_lit", rwd_data_out, 32'h44);
    run_op(0, 0, 0, mk_instr(3'b000, 5'd0), 32'h55, 0, 32'h50, 2'b00, 1, 0, 0);
    run_op(0, 0, 0, mk_instr(3'b000, 5'd2), 32'h66, 0, 32'hFFFF_FFFC, 2'b10, 1, 0, 0);
    check("wrap_rwd_lit", rwd_data_out, 32'h0);

    // Back-to-back ALU ops, one per cycle
    in_valid = 1'b1; mem_en = 1'b0; load = 1'b0; store = 1'b0; reg_write = 1'b1;
    mem_to_reg = 2'b00; instruction = mk_instr(3'b000, 5'd10); alu_result = 32'hA;
    @(posedge clk); #1;
    instruction = mk_instr(3'b000, 5'd11); alu_result = 32'hB;
    check("b2b_ready", {31'd0, in_ready}, 32'd1);
    check("b2b_rwd0", rwd_data_out, 32'hA);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("b2b_rwd1", rwd_data_out, 32'hB);
    check("b2b_pp1", {31'd0, decode_reg_write_pp}, 32'd1);
    exp_rwd = 32'hB; exp_ird = instruction;
    @(posedge clk); #1;

    // DM_valid in IDLE does nothing
    DM_valid = 1'b1; dm_rdata = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    DM_valid = 1'b0;
    check("idle_dmv_pp", {31'd0, decode_reg_write_pp}, 32'd0);
    check("idle_dmv_req", {31'd0, dm_req}, 32'd0);
    check("idle_dmv_rwd", rwd_data_out, exp_rwd);

    for (int n = 0; n < 300; n++) begin
      kind = $urandom_range(0, 2);
      a = $urandom;
      if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
      case (kind)
        0: begin
          logic en;
          logic [1:0] m;
          en = $urandom_range(0, 1);
          m = ($urandom_range(0, 2) == 0) ? 2'b00 : (($urandom_range(0, 1) == 1) ? 2'b10 : 2'b11);
          run_op(en, en ? 1'b0 : 1'($urandom), en ? 1'b0 : 1'($urandom), $urandom, a,
                 $urandom, $urandom, m, 1'($urandom), 0, 0);
        end
        1: run_op(1, 1, 1'($urandom), $urandom, a, $urandom, $urandom, 2'b01,
                  1'($urandom), $urandom, $urandom_range(0, 3));
        default: run_op(1, 0, 1, $urandom, a, $urandom, $urandom, 2'($urandom),
                        1'($urandom), $urandom, $urandom_range(0, 3));
      endcase
    end

    // Reset during WAIT drops the request at once; a late response is ignored
    in_valid = 1'b1; mem_en = 1'b1; load = 1'b1; store = 1'b0; reg_write = 1'b1;
    mem_to_reg = 2'b01; instruction = mk_instr(3'b010, 5'd4); alu_result = 32'h300;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("rstw_req_before", {31'd0, dm_req}, 32'd1);
    #2; rst = 1'b0; #1;
    check("rstw_req_drop", {31'd0, dm_req}, 32'd0);
    check("rstw_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    DM_valid = 1'b1; dm_rdata = 32'h1111_2222;
    @(posedge clk); #1;
    DM_valid = 1'b0;
    check("late_dmv_pp", {31'd0, decode_reg_write_pp}, 32'd0);
    check("late_dmv_req", {31'd0, dm_req}, 32'd0);
    check("late_dmv_ready", {31'd0, in_ready}, 32'd1);
    check("late_dmv_rwd", rwd_data_out, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
